dl2_backing_memory: RTL



---
 rtl/dl2_backing_memory_pkg.sv | 18 +
 rtl/dl2_mem_array.sv | 16 +
 rtl/dl2_backing_memory.sv | 126 ++++++++++++
 3 files changed

// File: rtl/dl2_backing_memory_pkg.sv
// dl2_backing_memory_pkg: shared FSM encoding, default latencies and block/beat geometry helpers
package dl2_backing_memory_pkg;
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_BURST = 3'd2,
    ST_WR_BURST = 3'd3,
    ST_WR_WAIT  = 3'd4
  } state_t;
  localparam int DEF_READ_LAT  = 10;
  localparam int DEF_WRITE_LAT = 4;
  function automatic int sub_log2(input int subblocks);
    return (subblocks > 1) ? $clog2(subblocks) : 1;
  endfunction
  function automatic int beat_bits(input int block_bits, input int subblocks);
    return block_bits / subblocks;
  endfunction
endpackage

// File: rtl/dl2_mem_array.sv
// dl2_mem_array: single-port beat array, synchronous write, combinational read
module dl2_mem_array #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dl2_backing_memory.sv
// dl2_backing_memory: DL2 main-memory model serving read bursts after READ_LAT and absorbing write-back bursts
module dl2_backing_memory
  import dl2_backing_memory_pkg::*;
#(
  parameter int ADDR_BITS       = 32,
  parameter int BLOCK_BITS      = 512,
  parameter int SUBBLOCKS       = 4,
  parameter int MEM_BLOCKS_LOG2 = 14,
  parameter int READ_LAT        = DEF_READ_LAT,
  parameter int WRITE_LAT       = DEF_WRITE_LAT,
  localparam int SUB_LOG2       = sub_log2(SUBBLOCKS),
  localparam int BEAT_BITS      = beat_bits(BLOCK_BITS, SUBBLOCKS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] addrD,
  input  logic                 enD,
  input  logic                 weD,
  input  logic [SUB_LOG2-1:0]  doutDstrobe,
  input  logic [BEAT_BITS-1:0] doutD,
  output logic [SUB_LOG2-1:0]  dinDstrobe,
  output logic [BEAT_BITS-1:0] dinD,
  output logic                 readyD,
  output logic                 accR,
  output logic                 accW
);
  localparam int OFF = $clog2(BLOCK_BITS / 8);
  localparam int CW  = $clog2((READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT) + 1;
  localparam int BW  = SUB_LOG2 + 1;
  state_t                     r_state, w_state_nxt;
  logic [MEM_BLOCKS_LOG2-1:0] r_blk, w_blk_nxt, w_req_blk, w_mem_blk;
  logic [CW-1:0]              r_cnt, w_cnt_nxt;
  logic [BW-1:0]              r_beat, w_beat_nxt;
  logic                       r_ready, w_ready_nxt, r_acc, w_acc_nxt;
  logic [BEAT_BITS-1:0]       r_din, w_din_nxt, w_rdata;
  logic [SUB_LOG2-1:0]        r_strobe, w_strobe_nxt, w_mem_beat;
  logic                       w_we, w_emit, w_unused;
  assign w_unused   = ^addrD;
  assign w_req_blk  = addrD[OFF +: MEM_BLOCKS_LOG2];
  assign w_mem_blk  = (r_state == ST_IDLE) ? w_req_blk : r_blk;
  assign w_mem_beat = w_we ? doutDstrobe : r_beat[SUB_LOG2-1:0];
  dl2_mem_array #(
    .ADDR_W(MEM_BLOCKS_LOG2 + SUB_LOG2),
    .DATA_W(BEAT_BITS)
  ) u_mem (
    .clk    (clk),
    .i_we   (w_we & ~reset),
    .i_addr ({w_mem_blk, w_mem_beat}),
    .i_wdata(doutD),
    .o_rdata(w_rdata)
  );
  // r_beat is the next beat to emit on reads and the count of captured beats on writes
  always_comb begin
    w_state_nxt  = r_state;
    w_blk_nxt    = r_blk;
    w_cnt_nxt    = r_cnt;
    w_beat_nxt   = r_beat;
    w_ready_nxt  = 1'b0;
    w_din_nxt    = '0;
    w_strobe_nxt = '0;
    w_we         = 1'b0;
    w_emit       = (r_state == ST_RD_WAIT && r_cnt == '0) ||
                   (r_state == ST_RD_BURST && r_beat != BW'(SUBBLOCKS));
    case (r_state)
      ST_IDLE: if (enD) begin
        w_blk_nxt   = w_req_blk;
        w_we        = weD;
        w_beat_nxt  = weD ? BW'(1) : '0;
        w_cnt_nxt   = weD ? CW'(WRITE_LAT - 1) : CW'(READ_LAT - 1);
        w_state_nxt = !weD ? ST_RD_WAIT : (SUBBLOCKS == 1) ? ST_WR_WAIT : ST_WR_BURST;
      end
      ST_RD_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == '0) w_state_nxt = ST_RD_BURST;
      end
      ST_RD_BURST: if (r_beat == BW'(SUBBLOCKS)) w_state_nxt = ST_IDLE;
      ST_WR_BURST: begin
        w_we       = 1'b1;
        w_beat_nxt = r_beat + BW'(1);
        if (r_beat == BW'(SUBBLOCKS - 1)) begin
          w_state_nxt = ST_WR_WAIT;
          w_cnt_nxt   = CW'(WRITE_LAT - 1);
        end
      end
      ST_WR_WAIT: begin
        w_cnt_nxt   = r_cnt - CW'(1);
        w_ready_nxt = !r_ready && r_cnt == '0;
        if (r_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_emit) begin
      w_ready_nxt  = 1'b1;
      w_din_nxt    = w_rdata;
      w_strobe_nxt = r_beat[SUB_LOG2-1:0];
      w_beat_nxt   = r_beat + BW'(1);
    end
    w_acc_nxt = (w_state_nxt == ST_IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_blk    <= '0;
      r_cnt    <= '0;
      r_beat   <= '0;
      r_ready  <= 1'b0;
      r_acc    <= 1'b1;
      r_din    <= '0;
      r_strobe <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_blk    <= w_blk_nxt;
      r_cnt    <= w_cnt_nxt;
      r_beat   <= w_beat_nxt;
      r_ready  <= w_ready_nxt;
      r_acc    <= w_acc_nxt;
      r_din    <= w_din_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end
  assign accR       = r_acc;
  assign accW       = r_acc;
  assign readyD     = r_ready;
  assign dinD       = r_din;
  assign dinDstrobe = r_strobe;
endmodule
